// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender for the decode stage.
// Widens an IN_W immediate to OUT_W using one of four modes and carries a
// destination tag with it. A registered output stage and a one-entry skid
// buffer allow a new transaction every cycle under valid/ready backpressure.
// IN_W must satisfy 2 <= IN_W < OUT_W.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int EXT_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] ext_data;

    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic [TAG_W-1:0] skid_tag;

    logic accept;
    logic out_free;
    logic skid_valid_next;

    assign sign_ext  = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    assign zero_ext  = {{EXT_W{1'b0}}, in_imm};
    assign upper_ext = {in_imm, {EXT_W{1'b0}}};

    // Apply the selected extension mode to the incoming immediate.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ext_data = sign_ext;
        unique case (mode_e'(in_mode))
            MODE_SIGN:   ext_data = sign_ext;
            MODE_ZERO:   ext_data = zero_ext;
            MODE_UPPER:  ext_data = upper_ext;
            MODE_BRANCH: ext_data = sign_ext << 2;
        endcase
    end

    assign accept   = in_valid & in_ready;
    assign out_free = !out_valid | out_ready;

    // The skid is occupied after this edge only if the output stays stalled
    // and it either already holds an entry or captures the incoming one.
    assign skid_valid_next = !out_free & (skid_valid | accept);

    // Output stage, skid buffer and registered in_ready.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_tag   <= '0;
            in_ready   <= 1'b1;
        end else begin
            in_ready <= !skid_valid_next;
            if (out_free) begin
                if (skid_valid) begin
                    // Older skid entry goes first; in_ready is low so nothing is accepted now.
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_tag    <= skid_tag;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    out_data  <= ext_data;
                    out_tag   <= in_tag;
                end else begin
                    // Data and tag keep their last value; only valid drops.
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                // Output is stalled: park the new result behind it.
                skid_valid <= 1'b1;
                skid_data  <= ext_data;
                skid_tag   <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and random-backpressure bench for imm_extend_pipe, with a second
// instance at IN_W=12/OUT_W=16 for the narrow-width vectors.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [11:0] s_in_imm;
    logic [1:0]  s_in_mode;
    logic [4:0]  s_in_tag;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_out_data;
    logic [4:0]  s_out_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(16), .TAG_W(5)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_imm(s_in_imm), .in_mode(s_in_mode), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_tag(s_out_tag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
        in_valid = v;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    // Reference extension for the 16->32 instance.
    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] s;
        s = 32'($signed(imm));
        case (mode)
            2'b00:   return s;
            2'b01:   return {16'h0000, imm};
            2'b10:   return {imm, 16'h0000};
            default: return s << 2;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [36:0]  q[$];
        logic [36:0]  head;
        logic [31:0]  held_data;
        logic [4:0]   held_tag;
        logic         acc;
        logic         pop;
        logic         hold;
        int           sent;
        int           rcvd;
        int           cyc;

        rst = 1'b1;
        drive(1'b0, 16'h0, 2'b00, 5'd0);
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_imm    = 12'h0;
        s_in_mode   = 2'b00;
        s_in_tag    = 5'd0;
        s_out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  out_data,       32'h0);
        check("rst_out_tag",   32'(out_tag),   32'd0);

        // Extension modes, one cycle latency
        drive(1'b1, 16'h8001, 2'b00, 5'd1); step();
        check("sign_8001_valid", 32'(out_valid), 32'd1);
        check("sign_8001", out_data, 32'hFFFF8001);
        check("sign_8001_tag", 32'(out_tag), 32'd1);
        drive(1'b1, 16'h8001, 2'b01, 5'd2); step();
        check("zero_8001", out_data, 32'h00008001);
        drive(1'b1, 16'h1234, 2'b10, 5'd3); step();
        check("upper_1234", out_data, 32'h12340000);
        drive(1'b1, 16'hFFFF, 2'b11, 5'd4); step();
        check("branch_ffff", out_data, 32'hFFFFFFFC);
        drive(1'b1, 16'h0004, 2'b11, 5'd5); step();
        check("branch_0004", out_data, 32'h00000010);
        drive(1'b1, 16'h7FFF, 2'b00, 5'd6); step();
        check("sign_7fff", out_data, 32'h00007FFF);
        check("sign_7fff_tag", 32'(out_tag), 32'd6);
        drive(1'b0, 16'h0, 2'b00, 5'd0); step();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Streaming: eight back-to-back transactions
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i * 3), 2'b01, 5'(i));
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_tag",   32'(out_tag),   32'(i));
            check("stream_data",  out_data,       32'(i * 3));
            check("stream_ready", 32'(in_ready),  32'd1);
        end
        drive(1'b0, 16'h0, 2'b00, 5'd0); step();
        check("stream_end_valid", 32'(out_valid), 32'd0);

        // Stall and skid: A held on output, B parked in skid
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, 2'b01, 5'd10); step();
        check("stall_a_valid", 32'(out_valid), 32'd1);
        check("stall_a_data",  out_data,       32'h000000AA);
        check("stall_ready_1", 32'(in_ready),  32'd1);
        drive(1'b1, 16'h00BB, 2'b01, 5'd11); step();
        check("stall_a_hold",  out_data,       32'h000000AA);
        check("stall_ready_0", 32'(in_ready),  32'd0);
        drive(1'b0, 16'h0, 2'b00, 5'd0); step();
        check("stall_a_hold2", out_data,       32'h000000AA);
        check("stall_a_tag",   32'(out_tag),   32'd10);
        check("stall_ready_0b", 32'(in_ready), 32'd0);
        out_ready = 1'b1; step();
        check("skid_b_valid", 32'(out_valid), 32'd1);
        check("skid_b_data",  out_data,       32'h000000BB);
        check("skid_b_tag",   32'(out_tag),   32'd11);
        check("skid_ready_1", 32'(in_ready),  32'd1);
        step();
        check("skid_drained", 32'(out_valid), 32'd0);

        // Random backpressure against a scoreboard
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 200 && cyc < 5000) begin
            in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            acc  = in_valid && in_ready;
            pop  = out_valid && out_ready;
            hold = out_valid && !out_ready;
            held_data = out_data;
            held_tag  = out_tag;
            if (pop) begin
                check("rand_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    head = q.pop_front();
                    check("rand_data", out_data,     head[31:0]);
                    check("rand_tag",  32'(out_tag), 32'(head[36:32]));
                end
                rcvd++;
            end
            if (acc) begin
                q.push_back({in_tag, model(in_imm, in_mode)});
                sent++;
            end
            step();
            cyc++;
            if (hold) begin
                check("rand_hold_valid", 32'(out_valid), 32'd1);
                check("rand_hold_data",  out_data,       held_data);
                check("rand_hold_tag",   32'(out_tag),   32'(held_tag));
            end
        end
        check("rand_received", 32'(rcvd), 32'd200);
        check("rand_left",     32'(q.size()), 32'd0);
        drive(1'b0, 16'h0, 2'b00, 5'd0);
        out_ready = 1'b1;
        step();

        // Reset while output stalled and skid full
        out_ready = 1'b0;
        drive(1'b1, 16'h0AAA, 2'b01, 5'd20); step();
        drive(1'b1, 16'h0BBB, 2'b01, 5'd21); step();
        check("pre_rst_ready", 32'(in_ready), 32'd0);
        drive(1'b0, 16'h0, 2'b00, 5'd0);
        rst = 1'b1; step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        check("mid_rst_data",  out_data,       32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_old", 32'(out_valid), 32'd0);
        end
        drive(1'b1, 16'h0C0C, 2'b10, 5'd22); step();
        check("post_rst_new_valid", 32'(out_valid), 32'd1);
        check("post_rst_new_data",  out_data,       32'h0C0C0000);
        check("post_rst_new_tag",   32'(out_tag),   32'd22);
        drive(1'b0, 16'h0, 2'b00, 5'd0); step();

        // Narrow instance: IN_W=12, OUT_W=16
        s_in_valid = 1'b1; s_in_imm = 12'h800; s_in_mode = 2'b00; s_in_tag = 5'd7; step();
        check("n_sign_valid", 32'(s_out_valid), 32'd1);
        check("n_sign_800",   32'(s_out_data),  32'h0000F800);
        check("n_sign_tag",   32'(s_out_tag),   32'd7);
        s_in_imm = 12'h800; s_in_mode = 2'b10; step();
        check("n_upper_800",  32'(s_out_data),  32'h00008000);
        s_in_imm = 12'hFFF; s_in_mode = 2'b11; step();
        check("n_branch_fff", 32'(s_out_data),  32'h0000FFFC);
        s_in_valid = 1'b0; step();
        check("n_idle_valid", 32'(s_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the datapath decode stage. It replaces the fixed 16-to-32 sign extender with a configurable IN_W-to-OUT_W extender. It supports four extension modes selected per transaction and carries a destination tag alongside the data. A registered output stage and a one-entry skid buffer give full-throughput valid/ready flow control between decode and execute.

Parameters:
IN_W, 16, immediate input width; 2 <= IN_W < OUT_W
OUT_W, 32, extended output width
TAG_W, 5, sideband tag width (destination register id), passed through unchanged

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream has a transaction
in_ready  output  1  unit can accept a transaction; registered
in_imm  input  IN_W  immediate field
in_mode  input  2  extension mode, see Behaviour
in_tag  input  TAG_W  sideband tag
out_valid  output  1  out_data/out_tag hold a valid result
out_ready  input  1  downstream accepts the result
out_data  output  OUT_W  extended result
out_tag  output  TAG_W  tag of the result

Behaviour:
- Modes, computed combinationally at input, OUT_W result:
  - 00 SIGN: in_imm[IN_W-1] replicated into bits OUT_W-1..IN_W.
  - 01 ZERO: upper bits 0.
  - 10 UPPER: in_imm placed at bits OUT_W-1..OUT_W-IN_W; lower bits 0.
  - 11 BRANCH: sign-extend, then shift left by 2; bits shifted past OUT_W-1 discarded; bits 1..0 = 0.
- State: output register (out_valid, out_data, out_tag); skid register (skid_valid, skid_data, skid_tag). Mode is applied before storage; the skid holds extended data.
- Accept = in_valid & in_ready. Output is free = !out_valid | out_ready.
- Per rising edge, rst=0:
  - Output free and skid_valid: skid moves to output; skid_valid <= 0. An accept cannot occur in the same cycle, because in_ready=0.
  - Output free, skid empty, accept: input result loads the output; out_valid <= 1.
  - Output free, skid empty, no accept: out_valid <= 0. out_data/out_tag are don't-care but hold their previous value.
  - Output stalled (out_valid & !out_ready) and accept: input result loads skid; skid_valid <= 1.
  - Output stalled, no accept: all state held. out_data/out_tag must remain stable while out_valid & !out_ready.
- in_ready <= !skid_valid_next. It is registered, so it drops in the cycle after the skid fills and rises in the cycle after the skid drains.
- Latency: a transaction accepted at edge N is presented (out_valid=1) in the cycle after edge N when the skid is empty.
- Throughput: one transaction per cycle while out_ready=1. Ordering is strictly FIFO; the skid entry always precedes any newer input.
- At most 2 transactions are in flight. No drop or duplication under any out_ready pattern.
- in_imm/in_mode/in_tag are sampled only on accept. Values while !in_valid are ignored.
- Reset, synchronous, overrides everything in that cycle:
  - out_valid=0, skid_valid=0, in_ready=1, out_data=0, out_tag=0.
  - In-flight transactions are discarded and never appear after reset.
- Upstream may drop in_valid at any time; no protocol error is flagged.

Test Plan:
- Modes, IN_W=16/OUT_W=32, out_ready=1:
  - 0x8001 mode00 -> 0xFFFF8001 one cycle later
  - 0x8001 mode01 -> 0x00008001
  - 0x1234 mode10 -> 0x12340000
  - 0xFFFF mode11 -> 0xFFFFFFFC
  - 0x0004 mode11 -> 0x00000010
  - 0x7FFF mode00 -> 0x00007FFF
- Streaming: 8 back-to-back accepts, tags 0..7, out_ready=1 -> outputs on 8 consecutive cycles in order, tags 0..7; in_ready stays 1.
- Stall/skid: out_ready=0, send A then B -> A on output, B in skid, in_ready=0 the following cycle. Raise out_ready -> A then B on consecutive cycles; in_ready returns to 1 one cycle after B moves out.
- Random backpressure: 200 transactions with random in_valid/out_ready -> scoreboard matches every data/tag in order, no loss or duplicate; out_data stable whenever out_valid & !out_ready.
- Reset mid-operation: skid full and output stalled, assert rst one cycle -> next cycle out_valid=0, in_ready=1, out_data=0. Pre-reset A/B never appear; a new transaction after reset appears normally.
- Parameter sweep: IN_W=12/OUT_W=16, 0x800 mode00 -> 0xF800; 0x800 mode10 -> 0x8000; 0xFFF mode11 -> 0xFFFC.
